stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Run controller for the stopwatch counter chain. Takes three raw push-buttons
//  (start/stop, lap, clear), synchronises and debounces them, and sequences the
//  counter through IDLE/RUN/LAP/PAUSED. Drives the chain's stop and clear inputs
//  and a display-freeze flag for lap times. Sits between board buttons and counter.
// PARAMETERS
//  DEBOUNCE_CYCLES  250000  consecutive stable cycles before a level is accepted (>=2)
//  DB_W             18      debounce counter width; 2**DB_W > DEBOUNCE_CYCLES
// PORTS
//  clk_base       in   1  system clock, all logic on rising edge
//  reset          in   1  asynchronous, active-low reset
//  btn_start_stop in   1  raw button, active-high, asynchronous to clk_base
//  btn_lap        in   1  raw button, active-high, asynchronous to clk_base
//  btn_clear      in   1  raw button, active-high, asynchronous to clk_base
//  run            out  1  1 = counter chain counts (counter stop = ~run)
//  clear_cnt      out  1  one-cycle pulse, zeroes the counter chain
//  lap_hold       out  1  1 = display shows frozen lap value
//  state          out  2  00 IDLE, 01 RUN, 11 LAP, 10 PAUSED
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, run=0, lap_hold=0, clear_cnt=0. Sync flops,
//   debounced levels and edge registers all 0; debounce counters 0.
//  Input path, per button: 2-flop synchroniser -> s.
//   If s==db, counter<=0. If s!=db, counter++; at count DEBOUNCE_CYCLES-1
//   db<=s and counter<=0. Glitches shorter than DEBOUNCE_CYCLES never change db.
//  Event = db & ~db_q (db_q = db delayed 1 cycle); single-cycle pulse per press.
//   Release generates no event. Holding a button gives exactly one event.
//  Latency: first edge sampling raw=1 is edge 0; state/outputs change on edge
//   DEBOUNCE_CYCLES+3, provided raw stays high throughout.
//  At most one event is acted on per cycle. Priority: start_stop > clear > lap.
//   Lower-priority events in the same cycle are dropped, not queued.
//  Transitions (events not listed are ignored, state held):
//   IDLE   : start_stop -> RUN; clear -> IDLE and pulse clear_cnt
//   RUN    : start_stop -> PAUSED; lap -> LAP
//   LAP    : lap -> RUN (release freeze); start_stop -> PAUSED
//   PAUSED : start_stop -> RUN; clear -> IDLE and pulse clear_cnt
//  Clear is ignored while counting (RUN, LAP).
//  Outputs are registered from next state: run=1 in RUN, LAP. lap_hold=1 only in LAP.
//   clear_cnt is high for exactly the one cycle where state first shows IDLE after
//   a clear.
//  state encoding is Gray-ordered, so run = state[0] and lap_hold = &state.
//  Reset mid-debounce discards partial counts. Reset mid-press: no event is produced
//   after reset release until the button is released and pressed again, because
//   db rises only after the full debounce from db=0.
//   Exception: a held button that is still high after reset release WILL produce
//   an event after DEBOUNCE_CYCLES+3 cycles. This is accepted behaviour.
// TESTING  (bench uses DEBOUNCE_CYCLES=4, DB_W=3)
//  1 Reset: reset=0 with all buttons high -> run=0, lap_hold=0, clear_cnt=0,
//    state=00. Release reset, hold 20 cycles -> exactly one IDLE->RUN at edge 7.
//  2 Bounce: start_stop toggled high 3 cycles / low 1 cycle x5, then low -> state
//    stays 00, run=0.
//  3 Full cycle: press start_stop -> 01/run=1. Press lap -> 11/lap_hold=1.
//    Press lap -> 01/lap_hold=0. Press start_stop -> 10/run=0.
//    Press clear -> 00 with clear_cnt=1 for exactly one cycle.
//  4 Clear while counting: in RUN and in LAP, press clear -> state unchanged,
//    clear_cnt never asserts.
//  5 Simultaneous: in PAUSED, press start_stop and clear on the same edge -> RUN,
//    no clear_cnt. In RUN, press clear and lap together -> LAP.
//  6 Async reset mid-operation: in LAP, pulse reset low for 1 ns between clock edges
//    -> outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Run controller for the stopwatch counter chain: synchronises and debounces
// three push-buttons and sequences the counter through IDLE/RUN/LAP/PAUSED.
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DB_W            = 18
) (
  input  logic       clk_base,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic       run,
  output logic       clear_cnt,
  output logic       lap_hold,
  output logic [1:0] state
);

  // Gray-ordered so run and lap_hold decode straight from the state bits.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    LAP    = 2'b11,
    PAUSED = 2'b10
  } state_t;

  localparam int BTN_SS  = 0;
  localparam int BTN_LAP = 1;
  localparam int BTN_CLR = 2;

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]      raw;
  logic [2:0]      sync1;
  logic [2:0]      sync2;
  logic [2:0]      db;
  logic [2:0]      db_q;
  logic [2:0]      evt;
  logic [DB_W-1:0] cnt [3];

  state_t state_r;
  state_t state_d;
  logic   clear_d;

  assign raw = {btn_clear, btn_lap, btn_start_stop};

  // A level is accepted only after it differs from db for DEBOUNCE_CYCLES edges in a row.
  always_ff @(posedge clk_base or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_q  <= '0;
      evt   <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      db_q  <= db;
      evt   <= db & ~db_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          db[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_base or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      clear_cnt <= 1'b0;
    end else begin
      state_r   <= state_d;
      clear_cnt <= clear_d;
    end
  end

  // start_stop outranks clear, which outranks lap; an ignored event never blocks a lower one.
  always_comb begin
    state_d = state_r;
    clear_d = 1'b0;
    case (state_r)
      IDLE: begin
        if (evt[BTN_SS]) begin
          state_d = RUN;
        end else if (evt[BTN_CLR]) begin
          state_d = IDLE;
          clear_d = 1'b1;
        end
      end
      RUN: begin
        if (evt[BTN_SS])       state_d = PAUSED;
        else if (evt[BTN_LAP]) state_d = LAP;
      end
      LAP: begin
        if (evt[BTN_SS])       state_d = PAUSED;
        else if (evt[BTN_LAP]) state_d = RUN;
      end
      PAUSED: begin
        if (evt[BTN_SS]) begin
          state_d = RUN;
        end else if (evt[BTN_CLR]) begin
          state_d = IDLE;
          clear_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign state    = state_r;
  assign run      = state_r[0];
  assign lap_hold = &state_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a short debounce window so each
// button press resolves in a handful of cycles.
module tb_stopwatch_ctrl;

  logic       clk_base = 1'b0;
  logic       reset    = 1'b0;
  logic       btn_start_stop = 1'b0;
  logic       btn_lap        = 1'b0;
  logic       btn_clear      = 1'b0;
  logic       run;
  logic       clear_cnt;
  logic       lap_hold;
  logic [1:0] state;

  int n_checks = 0;
  int n_fails  = 0;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(4), .DB_W(3)) dut (
    .clk_base       (clk_base),
    .reset          (reset),
    .btn_start_stop (btn_start_stop),
    .btn_lap        (btn_lap),
    .btn_clear      (btn_clear),
    .run            (run),
    .clear_cnt      (clear_cnt),
    .lap_hold       (lap_hold),
    .state          (state)
  );

  always #5 clk_base = ~clk_base;

  // btn is {start_stop, lap, clear}; pulses is the number of cycles clear_cnt was seen high.
  typedef struct {
    logic [2:0] btn;
    logic [1:0] exp_state;
    logic       exp_run;
    logic       exp_hold;
    int         exp_pulses;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_buttons(input logic [2:0] b);
    btn_start_stop = b[2];
    btn_lap        = b[1];
    btn_clear      = b[0];
  endtask

  task automatic press(input logic [2:0] b, output int pulses);
    pulses = 0;
    set_buttons(b);
    repeat (10) begin
      @(posedge clk_base); #1;
      if (clear_cnt) pulses++;
    end
    set_buttons(3'b000);
    repeat (10) begin
      @(posedge clk_base); #1;
      if (clear_cnt) pulses++;
    end
  endtask

  initial begin
    int         pulses;
    int         changes;
    logic [1:0] prev;

    vecs[0]  = '{3'b100, 2'b01, 1'b1, 1'b0, 0};
    vecs[1]  = '{3'b010, 2'b11, 1'b1, 1'b1, 0};
    vecs[2]  = '{3'b010, 2'b01, 1'b1, 1'b0, 0};
    vecs[3]  = '{3'b100, 2'b10, 1'b0, 1'b0, 0};
    vecs[4]  = '{3'b001, 2'b00, 1'b0, 1'b0, 1};
    vecs[5]  = '{3'b001, 2'b00, 1'b0, 1'b0, 1};
    vecs[6]  = '{3'b100, 2'b01, 1'b1, 1'b0, 0};
    vecs[7]  = '{3'b001, 2'b01, 1'b1, 1'b0, 0};
    vecs[8]  = '{3'b010, 2'b11, 1'b1, 1'b1, 0};
    vecs[9]  = '{3'b001, 2'b11, 1'b1, 1'b1, 0};
    vecs[10] = '{3'b100, 2'b10, 1'b0, 1'b0, 0};
    vecs[11] = '{3'b101, 2'b01, 1'b1, 1'b0, 0};
    vecs[12] = '{3'b011, 2'b11, 1'b1, 1'b1, 0};

    // Reset with every button held: all outputs idle while reset is low.
    set_buttons(3'b111);
    repeat (4) @(posedge clk_base);
    #1;
    check("rst_state", int'(state), 0);
    check("rst_run", int'(run), 0);
    check("rst_hold", int'(lap_hold), 0);
    check("rst_clear", int'(clear_cnt), 0);

    @(negedge clk_base);
    reset   = 1'b1;
    changes = 0;
    prev    = state;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_base); #1;
      if (state != prev) changes++;
      prev = state;
      if (i == 6) check("held_edge6_state", int'(state), 0);
      if (i == 7) begin
        check("held_edge7_state", int'(state), 1);
        check("held_edge7_run", int'(run), 1);
      end
    end
    check("held_transitions", changes, 1);
    check("held_final_state", int'(state), 1);
    set_buttons(3'b000);
    repeat (10) @(posedge clk_base);

    // Re-enter IDLE by reset, then bounce start_stop with glitches too short to accept.
    @(negedge clk_base);
    reset = 1'b0;
    @(negedge clk_base);
    reset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      btn_start_stop = 1'b1;
      repeat (3) begin
        @(posedge clk_base); #1;
        if (clear_cnt) pulses++;
      end
      btn_start_stop = 1'b0;
      @(posedge clk_base); #1;
    end
    repeat (12) @(posedge clk_base);
    #1;
    check("bounce_state", int'(state), 0);
    check("bounce_run", int'(run), 0);
    check("bounce_clear", pulses, 0);

    for (int v = 0; v < 13; v++) begin
      press(vecs[v].btn, pulses);
      check($sformatf("vec%0d_state", v), int'(state), int'(vecs[v].exp_state));
      check($sformatf("vec%0d_run", v), int'(run), int'(vecs[v].exp_run));
      check($sformatf("vec%0d_hold", v), int'(lap_hold), int'(vecs[v].exp_hold));
      check($sformatf("vec%0d_clear_pulses", v), pulses, vecs[v].exp_pulses);
    end

    // In LAP: short reset pulse between edges must clear outputs without a clock.
    #3;
    reset = 1'b0;
    #1;
    check("async_state", int'(state), 0);
    check("async_run", int'(run), 0);
    check("async_hold", int'(lap_hold), 0);
    check("async_clear", int'(clear_cnt), 0);
    reset = 1'b1;
    repeat (10) @(posedge clk_base);
    #1;
    check("post_async_state", int'(state), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
